// File: rtl/dualrail_channel_arbiter.sv
// dualrail_channel_arbiter: round-robin merge of two four-phase dual-rail channels (optional DUALRAIL_ARB_SYNC_INPUTS_EN input synchronizers)
module dualrail_channel_arbiter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_d0,
  input  logic [WIDTH-1:0] a_d1,
  output logic             a_e,
  input  logic [WIDTH-1:0] b_d0,
  input  logic [WIDTH-1:0] b_d1,
  output logic             b_e,
  output logic [WIDTH-1:0] r_d0,
  output logic [WIDTH-1:0] r_d1,
  input  logic             r_e,
  output logic             gnt,
  output logic             busy,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, WAIT_RDY, SEND, RETURN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] ad0, ad1, bd0, bd1, g0, g1;
  logic [WIDTH-1:0] lat0, lat1, lat0_n, lat1_n, r_d0_n, r_d1_n;
  logic re, a_ok, b_ok, pick, bad, a_e_n, b_e_n, gnt_n, err_n;
`ifdef DUALRAIL_ARB_SYNC_INPUTS_EN
  logic [4*WIDTH:0] s1, s2;
  always_ff @(posedge clk)
    if (reset) begin
      s1 <= {1'b1, {4*WIDTH{1'b0}}};
      s2 <= {1'b1, {4*WIDTH{1'b0}}};
    end else begin
      s1 <= {r_e, b_d1, b_d0, a_d1, a_d0};
      s2 <= s1;
    end
  assign {re, bd1, bd0, ad1, ad0} = s2;
`else
  assign {re, bd1, bd0, ad1, ad0} = {r_e, b_d1, b_d0, a_d1, a_d0};
`endif
  assign a_ok = &(ad0 ^ ad1);
  assign b_ok = &(bd0 ^ bd1);
  assign pick = (a_ok && b_ok) ? ~gnt : b_ok;
  assign g0 = gnt ? bd0 : ad0;
  assign g1 = gnt ? bd1 : ad1;
  assign bad = (|(ad0 & ad1)) | (|(bd0 & bd1)) |
               ((state == RETURN) && (|((g0 & ~lat0) | (g1 & ~lat1))));
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    lat0_n  = lat0;
    lat1_n  = lat1;
    r_d0_n  = r_d0;
    r_d1_n  = r_d1;
    a_e_n   = a_e;
    b_e_n   = b_e;
    gnt_n   = gnt;
    err_n   = err | bad;
    case (state)
      IDLE:
        if (a_ok || b_ok) begin
          gnt_n   = pick;
          lat0_n  = pick ? bd0 : ad0;
          lat1_n  = pick ? bd1 : ad1;
          a_e_n   = pick;
          b_e_n   = ~pick;
          state_n = re ? SEND : WAIT_RDY;
          r_d0_n  = re ? lat0_n : r_d0;
          r_d1_n  = re ? lat1_n : r_d1;
        end
      WAIT_RDY:
        if (re) begin
          r_d0_n  = lat0;
          r_d1_n  = lat1;
          state_n = SEND;
        end
      SEND:
        if (!re) begin
          r_d0_n  = '0;
          r_d1_n  = '0;
          state_n = RETURN;
        end
      RETURN:
        if (re && !(|(g0 | g1))) begin
          a_e_n   = 1'b1;
          b_e_n   = 1'b1;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      lat0  <= '0;
      lat1  <= '0;
      r_d0  <= '0;
      r_d1  <= '0;
      a_e   <= 1'b1;
      b_e   <= 1'b1;
      gnt   <= 1'b1;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      lat0  <= lat0_n;
      lat1  <= lat1_n;
      r_d0  <= r_d0_n;
      r_d1  <= r_d1_n;
      a_e   <= a_e_n;
      b_e   <= b_e_n;
      gnt   <= gnt_n;
      err   <= err_n;
    end
endmodule

// File: tb/tb_dualrail_channel_arbiter.sv
// tb_dualrail_channel_arbiter: directed self-checking bench for dualrail_channel_arbiter with WIDTH=2
module tb_dualrail_channel_arbiter;
`ifdef DUALRAIL_ARB_SYNC_INPUTS_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] a_d0 = '0, a_d1 = '0, b_d0 = '0, b_d1 = '0;
  logic [1:0] r_d0, r_d1;
  logic a_e, b_e, gnt, busy, err;
  logic r_e = 1'b1;
  int checks = 0;
  int errors = 0;
  dualrail_channel_arbiter #(.WIDTH(2)) dut (
    .clk(clk), .reset(reset),
    .a_d0(a_d0), .a_d1(a_d1), .a_e(a_e),
    .b_d0(b_d0), .b_d1(b_d1), .b_e(b_e),
    .r_d0(r_d0), .r_d1(r_d1), .r_e(r_e),
    .gnt(gnt), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    a_d0 = '0; a_d1 = '0; b_d0 = '0; b_d1 = '0; r_e = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({a_e, b_e, r_d1, r_d0, gnt, busy, err} !== 9'b11_00_00_1_0_0) begin
      errors++;
      $display("FAIL reset_state got %b exp %b", {a_e, b_e, r_d1, r_d0, gnt, busy, err}, 9'b11_00_00_1_0_0);
    end
  endtask
  task automatic test_basic();
    do_reset();
    a_d1 = 2'b01; a_d0 = 2'b10; r_e = 1'b1;
    tick(L);
    checks++;
    if ({r_d1, r_d0, busy} !== 5'b00_00_0) begin
      errors++;
      $display("FAIL basic_before_latency got %b exp %b", {r_d1, r_d0, busy}, 5'b00_00_0);
    end
    tick(1);
    checks++;
    if ({a_e, b_e, r_d1, r_d0, gnt, busy} !== 8'b0_1_01_10_0_1) begin
      errors++;
      $display("FAIL basic_send got %b exp %b", {a_e, b_e, r_d1, r_d0, gnt, busy}, 8'b0_1_01_10_0_1);
    end
    r_e = 1'b0;
    tick(1 + L);
    checks++;
    if ({a_e, r_d1, r_d0, busy} !== 6'b0_00_00_1) begin
      errors++;
      $display("FAIL basic_return got %b exp %b", {a_e, r_d1, r_d0, busy}, 6'b0_00_00_1);
    end
    a_d1 = '0; a_d0 = '0; r_e = 1'b1;
    tick(1 + L);
    checks++;
    if ({a_e, b_e, r_d1, r_d0, busy, err} !== 8'b1_1_00_00_0_0) begin
      errors++;
      $display("FAIL basic_idle got %b exp %b", {a_e, b_e, r_d1, r_d0, busy, err}, 8'b1_1_00_00_0_0);
    end
  endtask
  task automatic test_round_robin();
    logic g;
    logic [6:0] exp;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      g = k[0];
      exp = {g, g, ~g, g ? 2'b00 : 2'b11, g ? 2'b11 : 2'b00};
      a_d1 = 2'b11; a_d0 = 2'b00; b_d1 = 2'b00; b_d0 = 2'b11; r_e = 1'b1;
      tick(1 + L);
      checks++;
      if ({gnt, a_e, b_e, r_d1, r_d0} !== exp) begin
        errors++;
        $display("FAIL rr_grant_%0d got %b exp %b", k, {gnt, a_e, b_e, r_d1, r_d0}, exp);
      end
      r_e = 1'b0;
      tick(1 + L);
      a_d1 = '0; a_d0 = '0; b_d1 = '0; b_d0 = '0; r_e = 1'b1;
      tick(1 + L);
      checks++;
      if ({a_e, b_e, busy} !== 3'b110) begin
        errors++;
        $display("FAIL rr_idle_%0d got %b exp %b", k, {a_e, b_e, busy}, 3'b110);
      end
    end
  endtask
  task automatic test_wait_rdy();
    do_reset();
    r_e = 1'b0; a_d1 = 2'b01; a_d0 = 2'b10;
    tick(1 + L);
    checks++;
    if ({a_e, b_e, r_d1, r_d0, busy} !== 7'b0_1_00_00_1) begin
      errors++;
      $display("FAIL wait_enter got %b exp %b", {a_e, b_e, r_d1, r_d0, busy}, 7'b0_1_00_00_1);
    end
    a_d1 = 2'b10; a_d0 = 2'b01;
    tick(1 + L);
    checks++;
    if ({r_d1, r_d0, busy, err} !== 6'b00_00_1_0) begin
      errors++;
      $display("FAIL wait_hold got %b exp %b", {r_d1, r_d0, busy, err}, 6'b00_00_1_0);
    end
    r_e = 1'b1;
    tick(L);
    checks++;
    if ({r_d1, r_d0} !== 4'b00_00) begin
      errors++;
      $display("FAIL wait_before_latency got %b exp %b", {r_d1, r_d0}, 4'b00_00);
    end
    tick(1);
    checks++;
    if ({r_d1, r_d0, gnt} !== 5'b01_10_0) begin
      errors++;
      $display("FAIL wait_latched_send got %b exp %b", {r_d1, r_d0, gnt}, 5'b01_10_0);
    end
    r_e = 1'b0;
    tick(1 + L);
    checks++;
    if ({r_d1, r_d0, busy, err} !== 6'b00_00_1_0) begin
      errors++;
      $display("FAIL return_no_err_yet got %b exp %b", {r_d1, r_d0, busy, err}, 6'b00_00_1_0);
    end
    tick(1);
    checks++;
    if ({err, a_e} !== 2'b10) begin
      errors++;
      $display("FAIL return_value_change_err got %b exp %b", {err, a_e}, 2'b10);
    end
  endtask
  task automatic test_err();
    do_reset();
    r_e = 1'b1; b_d0 = 2'b01; b_d1 = 2'b01;
    tick(1 + L);
    checks++;
    if ({err, b_e, a_e, busy, r_d1, r_d0} !== 8'b1_1_1_0_00_00) begin
      errors++;
      $display("FAIL err_both_rails got %b exp %b", {err, b_e, a_e, busy, r_d1, r_d0}, 8'b1_1_1_0_00_00);
    end
    b_d0 = '0; b_d1 = '0;
    tick(3 + L);
    checks++;
    if ({err, busy} !== 2'b10) begin
      errors++;
      $display("FAIL err_sticky got %b exp %b", {err, busy}, 2'b10);
    end
    do_reset();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared_by_reset got %b exp %b", err, 1'b0);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    r_e = 1'b1; a_d1 = 2'b10; a_d0 = 2'b01;
    tick(1 + L);
    checks++;
    if ({busy, r_d1, r_d0} !== 5'b1_10_01) begin
      errors++;
      $display("FAIL midreset_send got %b exp %b", {busy, r_d1, r_d0}, 5'b1_10_01);
    end
    reset = 1'b1; a_d1 = '0; a_d0 = '0;
    tick(1);
    checks++;
    if ({r_d1, r_d0, a_e, b_e, busy, gnt} !== 8'b00_00_1_1_0_1) begin
      errors++;
      $display("FAIL midreset_clear got %b exp %b", {r_d1, r_d0, a_e, b_e, busy, gnt}, 8'b00_00_1_1_0_1);
    end
    reset = 1'b0;
    tick(4);
    checks++;
    if ({r_d1, r_d0, a_e, b_e, busy} !== 7'b00_00_1_1_0) begin
      errors++;
      $display("FAIL midreset_quiet got %b exp %b", {r_d1, r_d0, a_e, b_e, busy}, 7'b00_00_1_1_0);
    end
  endtask
  initial begin
    tick(1);
    test_reset();
    test_basic();
    test_round_robin();
    test_wait_rdy();
    test_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dualrail_channel_arbiter.md
DUALRAIL_CHANNEL_ARBITER -- requirements
Module: dualrail_channel_arbiter

Interface
REQ-001 Parameter: WIDTH, default 1, number of dual-rail data bits per channel (1..16).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a_d0, a_d1  input  WIDTH  requester A dual-rail data (bit i valid when exactly one of a_d0[i], a_d1[i] is high).
REQ-005 a_e  output  1  requester A enable (high = ready for token, low = token taken).
REQ-006 b_d0, b_d1  input  WIDTH  requester B dual-rail data.
REQ-007 b_e  output  1  requester B enable.
REQ-008 r_d0, r_d1  output  WIDTH  merged output channel dual-rail data.
REQ-009 r_e  input  1  output channel enable from receiver.
REQ-010 gnt  output  1  owner of the current or last transaction (0 = A, 1 = B).
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 err  output  1  sticky protocol error flag.

Function
REQ-013 Protocol SHALL be four-phase enable-based on all channels: sender drives data when e high; receiver drops e; sender returns to neutral (all rails low); receiver raises e.
REQ-014 Channel X valid SHALL mean every bit valid; neutral SHALL mean all rails low; anything else is incomplete and ignored.
REQ-015 States SHALL be IDLE, WAIT_RDY, SEND, RETURN.
REQ-016 IDLE: on a valid requester, arbitrate, latch its data, drop its e, set gnt; go SEND driving r_d from the latch if r_e=1, else go WAIT_RDY.
REQ-017 Both valid in the same IDLE cycle: grant the requester not in gnt (round-robin); a single valid requester SHALL win regardless of gnt.
REQ-018 WAIT_RDY: on r_e=1, drive r_d from the latch and go SEND.
REQ-019 SEND: hold r_d; on r_e=0, drive r_d neutral and go RETURN.
REQ-020 RETURN: when r_e=1 and granted input is neutral, raise the granted e and go IDLE; the earliest next grant is the following cycle.
REQ-021 Latency: valid input with r_e=1 SHALL produce valid r_d one cycle after the sampling edge.
REQ-022 r_d SHALL only change to latched data (WAIT_RDY/IDLE exit) or to neutral (SEND exit); the latch is frozen outside IDLE, so input changes mid-transaction never reach r_d.
REQ-023 The non-granted e SHALL remain high throughout; its pending token waits for IDLE.
REQ-024 err SHALL set when any input bit has both rails high in any state, or when the granted input leaves its value before neutral in RETURN; err clears only on reset.
REQ-025 Erroneous (both-rails) bits SHALL make that channel invalid for arbitration.

Reset
REQ-026 While reset high at an edge: state IDLE, a_e=1, b_e=1, r_d0=r_d1=0, gnt=1 (A wins first tie), busy=0, err=0, latch cleared.
REQ-027 Reset mid-transaction SHALL discard the latched token with no further output transitions until a new grant.

Configuration
REQ-028 Macro DUALRAIL_ARB_SYNC_INPUTS_EN: when defined, a_d0, a_d1, b_d0, b_d1 and r_e SHALL pass through two-flop synchronizers (reset to 0, r_e sync resets to 1) before use, adding exactly 2 cycles to every input-to-response latency; err uses synchronized values.
REQ-029 Without DUALRAIL_ARB_SYNC_INPUTS_EN, inputs SHALL be sampled directly and REQ-021 latency holds unmodified.

Verification
REQ-030 WIDTH=2, r_e=1, A drives d1=2'b01,d0=2'b10 -> next cycle a_e=0, r_d1=2'b01, r_d0=2'b10, gnt=0, busy=1.
REQ-031 After REQ-030, r_e=0 -> next cycle r_d neutral; A neutral, r_e=1 -> next cycle a_e=1, busy=0.
REQ-032 A and B valid same cycle after reset -> A granted; both re-presented -> B granted; repeat -> A (alternation over 4 tokens).
REQ-033 r_e=0 while A valid -> a_e=0, r_d stays neutral in WAIT_RDY; raising r_e -> r_d valid next cycle.
REQ-034 B drives b_d0[0]=b_d1[0]=1 -> err=1 next cycle, no grant to B; err remains 1 until reset.
REQ-035 Reset asserted in SEND -> next cycle r_d neutral, a_e=b_e=1, busy=0; with DUALRAIL_ARB_SYNC_INPUTS_EN, rerun REQ-030 and confirm r_d at 3 cycles.
